// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one memory port between icache refills and dcache reads/writebacks
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  icache2arb_req_i,
  input  logic                  icache2arb_kill_i,
  input  logic [ADDR_WIDTH-1:0] icache_addr_i,
  output logic                  arb2icache_ack_o,
  input  logic                  dcache2arb_req_i,
  input  logic                  dcache2arb_w_i,
  input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache_wdata_i,
  output logic                  arb2dcache_ack_o,
  output logic [LINE_WIDTH-1:0] arb2cache_rdata_o,
  output logic                  arb2mem_req_o,
  output logic                  arb2mem_w_o,
  output logic [ADDR_WIDTH-1:0] arb2mem_addr_o,
  output logic [LINE_WIDTH-1:0] arb2mem_wdata_o,
  input  logic                  mem2arb_ack_i,
  input  logic [LINE_WIDTH-1:0] mem2arb_rdata_i
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_ICACHE, ARB_DCACHE, ARB_DRAIN} state_t;
  state_t r_state, w_state;
  logic r_last_d, w_last_d;
  logic r_mem_req, w_mem_req, r_mem_w, w_mem_w, r_iack, w_iack, r_dack, w_dack;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [LINE_WIDTH-1:0] r_wdata, w_wdata, r_rdata, w_rdata;
  logic w_i_elig, w_d_elig;
  // a requester still holding req during its own ack cycle must not be granted again
  assign w_i_elig = icache2arb_req_i & ~icache2arb_kill_i & ~r_iack;
  assign w_d_elig = dcache2arb_req_i & ~r_dack;
  always_comb begin
    w_state   = r_state;
    w_last_d  = r_last_d;
    w_mem_req = r_mem_req;
    w_mem_w   = r_mem_w;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_iack    = 1'b0;
    w_dack    = 1'b0;
    w_rdata   = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_i_elig && (!w_d_elig || r_last_d)) begin
          w_state   = ARB_ICACHE;
          w_last_d  = 1'b0;
          w_mem_req = 1'b1;
          w_mem_w   = 1'b0;
          w_addr    = icache_addr_i;
          w_wdata   = '0;
        end else if (w_d_elig) begin
          w_state   = ARB_DCACHE;
          w_last_d  = 1'b1;
          w_mem_req = 1'b1;
          w_mem_w   = dcache2arb_w_i;
          w_addr    = dcache_addr_i;
          w_wdata   = dcache_wdata_i;
        end
      end
      ARB_ICACHE: begin
        if (mem2arb_ack_i) begin
          w_state   = ARB_IDLE;
          w_mem_req = 1'b0;
          w_iack    = ~icache2arb_kill_i;
          w_rdata   = icache2arb_kill_i ? '0 : mem2arb_rdata_i;
        end else if (icache2arb_kill_i) begin
          w_state   = ARB_DRAIN;
        end
      end
      ARB_DCACHE: begin
        if (mem2arb_ack_i) begin
          w_state   = ARB_IDLE;
          w_mem_req = 1'b0;
          w_dack    = 1'b1;
          w_rdata   = r_mem_w ? '0 : mem2arb_rdata_i;
        end
      end
      ARB_DRAIN: begin
        if (mem2arb_ack_i) begin
          w_state   = ARB_IDLE;
          w_mem_req = 1'b0;
        end
      end
      default: w_state = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ARB_IDLE;
      r_last_d  <= 1'b1;
      r_mem_req <= 1'b0;
      r_mem_w   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_iack    <= 1'b0;
      r_dack    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state;
      r_last_d  <= w_last_d;
      r_mem_req <= w_mem_req;
      r_mem_w   <= w_mem_w;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_iack    <= w_iack;
      r_dack    <= w_dack;
      r_rdata   <= w_rdata;
    end
  end
  assign arb2icache_ack_o  = r_iack;
  assign arb2dcache_ack_o  = r_dack;
  assign arb2cache_rdata_o = r_rdata;
  assign arb2mem_req_o     = r_mem_req;
  assign arb2mem_w_o       = r_mem_w;
  assign arb2mem_addr_o    = r_addr;
  assign arb2mem_wdata_o   = r_wdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed stimulus with a queue of expected memory grants and cache acks,
// checked in order and on the exact cycle by an independent negedge monitor.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int K_MEM = 0;
  localparam int K_I = 1;
  localparam int K_D = 2;
  logic clk = 0, rst_ni = 0, ireq = 0, kill = 0, dreq = 0, dw = 0, mack = 0;
  logic [AW-1:0] iaddr = '0, daddr = '0;
  logic [LW-1:0] dwdata = '0, mrdata = '0;
  logic iack, dack, mreq, mw;
  logic [AW-1:0] maddr;
  logic [LW-1:0] rdata, mwdata;
  int vectors = 0, miscompares = 0, cyc = 0;
  bit mon_en = 0;
  logic prev_req = 0, prev_ack = 0, prev_rst = 0;
  typedef struct {int kind; int at; logic w; logic [AW-1:0] addr; logic [LW-1:0] data;} exp_t;
  exp_t q[$];
  localparam logic [LW-1:0] JUNK = {4{32'h5A5A_F00D}};

  cache_mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .icache2arb_req_i(ireq), .icache2arb_kill_i(kill), .icache_addr_i(iaddr),
    .arb2icache_ack_o(iack),
    .dcache2arb_req_i(dreq), .dcache2arb_w_i(dw), .dcache_addr_i(daddr), .dcache_wdata_i(dwdata),
    .arb2dcache_ack_o(dack), .arb2cache_rdata_o(rdata),
    .arb2mem_req_o(mreq), .arb2mem_w_o(mw), .arb2mem_addr_o(maddr), .arb2mem_wdata_o(mwdata),
    .mem2arb_ack_i(mack), .mem2arb_rdata_i(mrdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input int kind, input string name);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected output at cycle %0d, none required", name, cyc);
      return;
    end
    e = q.pop_front();
    chk({name, "_kind"}, kind, e.kind);
    chk({name, "_cycle"}, cyc, e.at);
    if (kind == K_MEM) begin
      chk({name, "_addr"}, maddr, e.addr);
      chk({name, "_w"}, mw, e.w);
      chk({name, "_wdata"}, mwdata, e.data);
    end else begin
      chk({name, "_rdata"}, rdata, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mreq && !prev_req) pop_chk(K_MEM, "mem_grant");
      if (iack) pop_chk(K_I, "icache_ack");
      if (dack) pop_chk(K_D, "dcache_ack");
      if (!iack && !dack) chk("rdata_idle", rdata, '0);
      else chk("single_ack", iack & dack, 1'b0);
      if (prev_rst && prev_req) chk("mem_req_hold", mreq, !prev_ack);
    end
    prev_req <= mreq;
    prev_ack <= mack;
    prev_rst <= rst_ni;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int at, input logic w, input logic [AW-1:0] a,
                      input logic [LW-1:0] d);
    exp_t e;
    e.kind = kind;
    e.at = at;
    e.w = w;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic do_reset;
    rst_ni = 0;
    tick;
    @(negedge clk);
    chk("rst_mem_req", mreq, 1'b0);
    chk("rst_mem_w", mw, 1'b0);
    chk("rst_mem_addr", maddr, '0);
    chk("rst_mem_wdata", mwdata, '0);
    chk("rst_iack", iack, 1'b0);
    chk("rst_dack", dack, 1'b0);
    chk("rst_rdata", rdata, '0);
    tick;
    rst_ni = 1;
  endtask

  initial begin
    int kinds[4];
    logic [LW-1:0] d;
    kinds = '{K_I, K_D, K_I, K_D};
    tick;
    do_reset;
    mon_en = 1;
    // 1: single icache refill, mem ack 3 cycles after req_o
    ireq = 1; iaddr = 32'h8000_0040;
    push(K_MEM, cyc + 1, 1'b0, 32'h8000_0040, '0);
    repeat (4) tick;
    mack = 1; mrdata = 128'h0123456789abcdef_fedcba9876543210;
    push(K_I, cyc + 1, 1'b0, '0, 128'h0123456789abcdef_fedcba9876543210);
    tick;
    mack = 0; mrdata = '0; ireq = 0;
    // 2: simultaneous requests after reset, icache wins, then dcache writeback
    do_reset;
    ireq = 1; iaddr = 32'h2000; dreq = 1; dw = 1; daddr = 32'h100; dwdata = {16{8'hA5}};
    push(K_MEM, cyc + 1, 1'b0, 32'h2000, '0);
    tick;
    mack = 1; mrdata = {4{32'h1111_2222}};
    push(K_I, cyc + 1, 1'b0, '0, {4{32'h1111_2222}});
    tick;
    mack = 0; mrdata = '0; ireq = 0;
    push(K_MEM, cyc + 1, 1'b1, 32'h100, {16{8'hA5}});
    tick;
    mack = 1; mrdata = JUNK;
    push(K_D, cyc + 1, 1'b0, '0, '0);
    tick;
    mack = 0; mrdata = '0; dreq = 0; dw = 0; dwdata = '0;
    // 3: both held across four transactions, alternating I,D,I,D
    ireq = 1; iaddr = 32'h3000; dreq = 1; dw = 0; daddr = 32'h3100;
    push(K_MEM, cyc + 1, 1'b0, 32'h3000, '0);
    for (int k = 0; k < 4; k++) begin
      tick;
      d = {4{32'hC0DE_0000 + 32'(k)}};
      mack = 1; mrdata = d;
      push(kinds[k], cyc + 1, 1'b0, '0, d);
      tick;
      mack = 0; mrdata = '0;
      if (k < 3) push(K_MEM, cyc + 1, 1'b0, (kinds[k+1] == K_I) ? 32'h3000 : 32'h3100, '0);
      else begin ireq = 0; dreq = 0; end
    end
    // 4: icache kill one cycle after req_o rises, pending dcache write follows the drain
    ireq = 1; iaddr = 32'h4000;
    push(K_MEM, cyc + 1, 1'b0, 32'h4000, '0);
    tick;
    dreq = 1; dw = 1; daddr = 32'h4400; dwdata = {4{32'hDEAD_BEEF}};
    tick;
    kill = 1;
    tick;
    kill = 0; ireq = 0;
    tick;
    tick;
    mack = 1; mrdata = JUNK;
    push(K_MEM, cyc + 2, 1'b1, 32'h4400, {4{32'hDEAD_BEEF}});
    tick;
    mack = 0; mrdata = '0;
    tick;
    mack = 1; mrdata = JUNK;
    push(K_D, cyc + 1, 1'b0, '0, '0);
    tick;
    mack = 0; mrdata = '0; dreq = 0; dw = 0; dwdata = '0;
    // 5: kill coincident with mem ack, then kill during a dcache read is ignored
    ireq = 1; iaddr = 32'h5000;
    push(K_MEM, cyc + 1, 1'b0, 32'h5000, '0);
    tick;
    mack = 1; kill = 1; mrdata = JUNK;
    tick;
    mack = 0; kill = 0; ireq = 0; mrdata = '0;
    dreq = 1; dw = 0; daddr = 32'h5500;
    push(K_MEM, cyc + 1, 1'b0, 32'h5500, '0);
    tick;
    kill = 1;
    tick;
    mack = 1; mrdata = {4{32'h7777_5555}};
    push(K_D, cyc + 1, 1'b0, '0, {4{32'h7777_5555}});
    tick;
    mack = 0; mrdata = '0; kill = 0; dreq = 0;
    // stray mem ack while idle must produce nothing
    tick;
    mack = 1; mrdata = JUNK;
    tick;
    mack = 0; mrdata = '0;
    tick;
    // 6: reset while waiting for mem ack, late ack is ignored
    ireq = 1; iaddr = 32'h6000;
    push(K_MEM, cyc + 1, 1'b0, 32'h6000, '0);
    tick;
    tick;
    ireq = 0;
    do_reset;
    mack = 1; mrdata = JUNK;
    tick;
    mack = 0; mrdata = '0;
    repeat (3) tick;
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
